// File: rtl/scr1_dma_pkg.sv
// DMA engine shared definitions: FSM state encoding (visible to the CSR wrapper
// for status decode), word stride and the word-alignment helper.
// No ports.
package scr1_dma_pkg;

    typedef enum logic [2:0] {
        SCR1_DMA_IDLE    = 3'd0,
        SCR1_DMA_RD_REQ  = 3'd1,
        SCR1_DMA_RD_RESP = 3'd2,
        SCR1_DMA_WR_REQ  = 3'd3,
        SCR1_DMA_WR_RESP = 3'd4
    } type_scr1_dma_state_e;

    localparam logic [31:0] SCR1_DMA_WORD_STRIDE = 32'd4;

    // Byte address to word address: the engine only moves whole words.
    function automatic logic [31:0] scr1_dma_word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage : scr1_dma_pkg

// File: rtl/scr1_memif_pkg.sv
// Shared SCR1 memory-interface types: command, access width and response codes
// used by every dmem/imem initiator and responder in the core.
// No ports; imported by dmem-side blocks.
package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10,
        SCR1_MEM_RESP_ERROR  = 2'b11
    } type_scr1_mem_resp_e;

endpackage : scr1_memif_pkg

// File: rtl/scr1_dmem_dma.sv
// Purpose: single-channel word-copy engine, initiator on the SCR1 dmem interface.
// Latency: 4 cycles per word with a zero-wait responder; done at cycle 4N+1 after start.
// Backpressure: req/cmd/addr/wdata held until req_ack; NOTRDY responses wait indefinitely.
// Ports: start/src_addr/dst_addr/len control; busy/done/error/err_addr/words_done status;
//        dmem_req..dmem_wdata request channel; dmem_req_ack/dmem_rdata/dmem_resp response side.
module scr1_dmem_dma
    import scr1_memif_pkg::*;
    import scr1_dma_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          err_addr,
    output logic [LEN_W-1:0]     words_done,
    output logic                 dmem_req,
    output type_scr1_mem_cmd_e   dmem_cmd,
    output type_scr1_mem_width_e dmem_width,
    output logic [31:0]          dmem_addr,
    output logic [31:0]          dmem_wdata,
    input  logic                 dmem_req_ack,
    input  logic [31:0]          dmem_rdata,
    input  type_scr1_mem_resp_e  dmem_resp
);

    type_scr1_dma_state_e state;
    logic [31:0]          src_ptr;
    logic [31:0]          dst_ptr;
    logic [LEN_W-1:0]     remaining;

    assign dmem_width = SCR1_MEM_WIDTH_WORD;

    // dmem_wdata doubles as the read-data buffer between the read and write halves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SCR1_DMA_IDLE;
            src_ptr    <= '0;
            dst_ptr    <= '0;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            err_addr   <= '0;
            words_done <= '0;
            dmem_req   <= 1'b0;
            dmem_cmd   <= SCR1_MEM_CMD_RD;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                SCR1_DMA_IDLE: begin
                    if (start) begin
                        error      <= 1'b0;
                        words_done <= '0;
                        if (len != '0) begin
                            src_ptr   <= scr1_dma_word_align(src_addr);
                            dst_ptr   <= scr1_dma_word_align(dst_addr);
                            remaining <= len;
                            busy      <= 1'b1;
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= SCR1_MEM_CMD_RD;
                            dmem_addr <= scr1_dma_word_align(src_addr);
                            state     <= SCR1_DMA_RD_REQ;
                        end else begin
                            // Empty copy completes without touching the bus.
                            done <= 1'b1;
                        end
                    end
                end
                SCR1_DMA_RD_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req <= 1'b0;
                        state    <= SCR1_DMA_RD_RESP;
                    end
                end
                SCR1_DMA_RD_RESP: begin
                    if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                        dmem_wdata <= dmem_rdata;
                        dmem_req   <= 1'b1;
                        dmem_cmd   <= SCR1_MEM_CMD_WR;
                        dmem_addr  <= dst_ptr;
                        state      <= SCR1_DMA_WR_REQ;
                    end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                        error    <= 1'b1;
                        err_addr <= src_ptr;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= SCR1_DMA_IDLE;
                    end
                end
                SCR1_DMA_WR_REQ: begin
                    if (dmem_req_ack) begin
                        dmem_req <= 1'b0;
                        state    <= SCR1_DMA_WR_RESP;
                    end
                end
                SCR1_DMA_WR_RESP: begin
                    if (dmem_resp == SCR1_MEM_RESP_RDY_OK) begin
                        words_done <= words_done + 1'b1;
                        src_ptr    <= src_ptr + SCR1_DMA_WORD_STRIDE;
                        dst_ptr    <= dst_ptr + SCR1_DMA_WORD_STRIDE;
                        remaining  <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= SCR1_DMA_IDLE;
                        end else begin
                            // Next read issued straight away; pointer wraps modulo 2^32.
                            dmem_req  <= 1'b1;
                            dmem_cmd  <= SCR1_MEM_CMD_RD;
                            dmem_addr <= src_ptr + SCR1_DMA_WORD_STRIDE;
                            state     <= SCR1_DMA_RD_REQ;
                        end
                    end else if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
                        error    <= 1'b1;
                        err_addr <= dst_ptr;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= SCR1_DMA_IDLE;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    busy     <= 1'b0;
                    state    <= SCR1_DMA_IDLE;
                end
            endcase
        end
    end

endmodule : scr1_dmem_dma

// File: tb/tb_scr1_dmem_dma.sv
// Bench for scr1_dmem_dma: memory responder with programmable ack/response stalls
// and error injection; expected bus traffic, status and timing come from a
// word-level copy model built from addresses, lengths and the memory image.
module tb_scr1_dmem_dma;
    import scr1_memif_pkg::*;
    import scr1_dma_pkg::*;

    localparam int LEN_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [31:0]          src_addr = '0;
    logic [31:0]          dst_addr = '0;
    logic [LEN_W-1:0]     len = '0;
    logic                 busy, done, error;
    logic [31:0]          err_addr;
    logic [LEN_W-1:0]     words_done;
    logic                 dmem_req;
    type_scr1_mem_cmd_e   dmem_cmd;
    type_scr1_mem_width_e dmem_width;
    logic [31:0]          dmem_addr, dmem_wdata;
    logic                 dmem_req_ack;
    logic [31:0]          dmem_rdata = '0;
    type_scr1_mem_resp_e  dmem_resp = SCR1_MEM_RESP_NOTRDY;

    scr1_dmem_dma #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .error(error), .err_addr(err_addr),
        .words_done(words_done), .dmem_req(dmem_req), .dmem_cmd(dmem_cmd),
        .dmem_width(dmem_width), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_req_ack(dmem_req_ack), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- responder ----------------
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic [31:0] mem [logic [31:0]];
    xfer_t       log_q[$];
    int          ack_wait = 0, resp_wait = 0, err_at = -1, xfer_cnt = 0;
    int          wcnt = 0, rcnt = 0, req_cyc = 0, stab_viol = 0, ovl_viol = 0;
    logic        pend = 1'b0, p_wr = 1'b0, p_err = 1'b0;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic        prev_wait = 1'b0;
    logic        prev_cmd = 1'b0;
    logic [31:0] prev_addr = '0, prev_wdata = '0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    assign dmem_req_ack = dmem_req && (wcnt >= ack_wait);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      = 1'b0;
            wcnt      <= 0;
            prev_wait <= 1'b0;
            dmem_resp <= SCR1_MEM_RESP_NOTRDY;
        end else begin
            if (dmem_req) req_cyc++;
            if (dmem_req && pend) ovl_viol++;
            if (prev_wait && !(dmem_req && dmem_cmd == type_scr1_mem_cmd_e'(prev_cmd) &&
                dmem_addr == prev_addr && (!prev_cmd || dmem_wdata == prev_wdata)))
                stab_viol++;
            prev_wait  <= dmem_req && !dmem_req_ack;
            prev_cmd   <= dmem_cmd;
            prev_addr  <= dmem_addr;
            prev_wdata <= dmem_wdata;
            dmem_resp  <= SCR1_MEM_RESP_NOTRDY;
            if (dmem_req && !dmem_req_ack) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (dmem_req && dmem_req_ack) begin
                p_wr    = (dmem_cmd == SCR1_MEM_CMD_WR);
                p_addr  = dmem_addr;
                p_wdata = dmem_wdata;
                p_err   = (xfer_cnt == err_at);
                xfer_cnt++;
                rcnt    = resp_wait;
                pend    = 1'b1;
                log_q.push_back('{p_wr, p_addr, p_wr ? p_wdata : mem_rd(p_addr)});
            end
            if (pend) begin
                if (rcnt == 0) begin
                    pend = 1'b0;
                    if (p_err) dmem_resp <= SCR1_MEM_RESP_RDY_ER;
                    else begin
                        dmem_resp <= SCR1_MEM_RESP_RDY_OK;
                        if (p_wr) mem[p_addr] = p_wdata;
                        else dmem_rdata <= mem_rd(p_addr);
                    end
                end else rcnt--;
            end
        end
    end

    // ---------------- one copy job against the model ----------------
    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int aw, input int rw, input int e_idx,
                            input bit check_time, input bit poke);
        xfer_t       exp_q[$];
        logic [31:0] src_img[$];
        logic [31:0] ra, wa, exp_err_addr;
        int          idx, exp_words, cyc, busy_bad, req0, idle_req;
        bit          exp_err;
        ack_wait = aw; resp_wait = rw; err_at = e_idx;
        xfer_cnt = 0; log_q.delete();
        for (int i = 0; i < n; i++) begin
            ra = {s[31:2], 2'b00} + 32'(4 * i);
            wa = {d[31:2], 2'b00} + 32'(4 * i);
            mem[ra] = $urandom;
            mem[wa] = $urandom;
        end
        // Model: read word i then write it, stopping at the injected failure.
        idx = 0; exp_words = 0; exp_err = 0; exp_err_addr = 0;
        for (int i = 0; i < n; i++) begin
            ra = {s[31:2], 2'b00} + 32'(4 * i);
            wa = {d[31:2], 2'b00} + 32'(4 * i);
            src_img.push_back(mem[ra]);
            exp_q.push_back('{1'b0, ra, mem[ra]});
            if (idx == e_idx) begin exp_err = 1; exp_err_addr = ra; break; end
            idx++;
            exp_q.push_back('{1'b1, wa, mem[ra]});
            if (idx == e_idx) begin exp_err = 1; exp_err_addr = wa; break; end
            idx++;
            exp_words++;
        end
        req0 = req_cyc;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = LEN_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; busy_bad = 0;
        while (!done && cyc < 2000) begin
            if (busy !== (n != 0)) busy_bad++;
            @(negedge clk);
            cyc++;
            if (poke && cyc == 3) begin
                start = 1'b1; len = 16'd7; src_addr = 32'h5000; dst_addr = 32'h6000;
            end else start = 1'b0;
        end
        start = 1'b0;
        chk("done_seen", 32'(done), 32'd1);
        chk("busy_before_done", busy_bad, 0);
        chk("busy_at_done", 32'(busy), 32'd0);
        if (check_time) chk("done_cycle", cyc, 4 * n + n * 2 * (aw + rw));
        chk("error", 32'(error), 32'(exp_err));
        if (exp_err) chk("err_addr", err_addr, exp_err_addr);
        chk("words_done", 32'(words_done), exp_words);
        @(negedge clk);
        chk("done_pulse_width", 32'(done), 32'd0);
        idle_req = 0;
        for (int k = 0; k < 4; k++) begin
            if (dmem_req) idle_req++;
            @(negedge clk);
        end
        chk("idle_no_req", idle_req, 0);
        if (n == 0) chk("len0_no_req", req_cyc - req0, 0);
        chk("xfer_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            chk("xfer_cmd", 32'(log_q[i].wr), 32'(exp_q[i].wr));
            chk("xfer_addr", log_q[i].addr, exp_q[i].addr);
            chk("xfer_data", log_q[i].data, exp_q[i].data);
        end
        if (!exp_err)
            for (int i = 0; i < n; i++)
                chk("dst_word", mem_rd({d[31:2], 2'b00} + 32'(4 * i)), src_img[i]);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_busy"}, 32'(busy), 0);
        chk({pfx, "_done"}, 32'(done), 0);
        chk({pfx, "_error"}, 32'(error), 0);
        chk({pfx, "_req"}, 32'(dmem_req), 0);
        chk({pfx, "_err_addr"}, err_addr, 0);
        chk({pfx, "_words_done"}, 32'(words_done), 0);
        chk({pfx, "_addr"}, dmem_addr, 0);
        chk({pfx, "_wdata"}, dmem_wdata, 0);
        chk({pfx, "_cmd"}, 32'(dmem_cmd), 32'(SCR1_MEM_CMD_RD));
        chk({pfx, "_width"}, 32'(dmem_width), 32'(SCR1_MEM_WIDTH_WORD));
    endtask

    initial begin
        int wait_cyc;
        #12;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // zero-wait, 3 words: done at cycle 13
        run_copy(32'h100, 32'h200, 3, 0, 0, -1, 1, 0);
        // ack held low 3 cycles and 2 NOTRDY cycles per transfer
        run_copy(32'h400, 32'h600, 3, 3, 2, -1, 1, 0);
        // second read fails
        run_copy(32'h800, 32'hA00, 4, 0, 0, 2, 0, 0);
        // empty copy
        run_copy(32'h900, 32'hB00, 0, 0, 0, -1, 1, 0);
        // source wraps past the top of the address space; start poked while busy
        run_copy(32'hFFFF_FFFC, 32'h300, 2, 0, 0, -1, 1, 1);
        // first write fails, with stalls
        run_copy(32'hC00, 32'hD00, 3, 1, 1, 1, 0, 0);
        // randomized jobs; low address bits are junk and must be ignored
        for (int r = 0; r < 6; r++) begin
            logic [31:0] s;
            int          n, e;
            s = 32'h1_0000 + 32'($urandom_range(0, 255)) * 32'h40 + 32'($urandom_range(0, 3));
            n = $urandom_range(1, 5);
            e = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 2 * n - 1) : -1;
            run_copy(s, s + 32'h8_0000 + 32'($urandom_range(0, 3)), n,
                     $urandom_range(0, 2), $urandom_range(0, 2), e, (e < 0), 0);
        end

        // asynchronous reset while a write request is waiting for ack
        ack_wait = 6; resp_wait = 0; err_at = -1;
        @(negedge clk);
        src_addr = 32'h2000; dst_addr = 32'h3000; len = 16'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!(dmem_req && dmem_cmd == SCR1_MEM_CMD_WR) && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("reached_wr_req", 32'(dmem_req && dmem_cmd == SCR1_MEM_CMD_WR), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_copy(32'h2000, 32'h3000, 3, 0, 0, -1, 1, 0);

        chk("req_stable_while_unacked", stab_viol, 0);
        chk("single_outstanding", ovl_viol, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_scr1_dmem_dma
